// File: rtl/line_follow_pkg.sv
// Shared types, widths and helpers for the line-following steering controller.
package line_follow_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        SEARCH = 2'd2,
        STOP   = 2'd3
    } ctrl_state_t;

    localparam int ERR_W = 12;

    function automatic int duty_w(input int period);
        return $clog2(period + 1);
    endfunction

    localparam int DUTY_W = duty_w(1000);

    // Saturate a signed duty request into [0, hi].
    function automatic logic signed [ERR_W:0] clamp_duty(input logic signed [ERR_W:0] v,
                                                         input logic signed [ERR_W:0] hi);
        if (v < 0)
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/line_follow_ctrl_pwm_gen.sv
// Dual-channel PWM: free-running period counter, shadow->active duty registers
// updated only at the period boundary, and flopped compare outputs.
module pwm_gen #(
    parameter int PWM_PERIOD = 1000,
    parameter int DW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] shadow_l,
    input  logic [DW-1:0] shadow_r,
    output logic          pwm_left,
    output logic          pwm_right
);

    localparam logic [DW-1:0] PCNT_LAST = DW'(PWM_PERIOD - 1);

    logic [DW-1:0] pcnt;
    logic [DW-1:0] sh_l, sh_r;
    logic [DW-1:0] act_l, act_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt      <= '0;
            sh_l      <= '0;
            sh_r      <= '0;
            act_l     <= '0;
            act_r     <= '0;
            pwm_left  <= 1'b0;
            pwm_right <= 1'b0;
        end else begin
            if (load) begin
                sh_l <= shadow_l;
                sh_r <= shadow_r;
            end
            // Active duties only change at the wrap so every period is whole.
            if (pcnt == PCNT_LAST) begin
                pcnt  <= '0;
                act_l <= sh_l;
                act_r <= sh_r;
            end else begin
                pcnt <= pcnt + DW'(1);
            end
            pwm_left  <= (pcnt < act_l);
            pwm_right <= (pcnt < act_r);
        end
    end

endmodule

// File: rtl/line_follow_ctrl.sv
// Proportional steering controller with TRACK/SEARCH/STOP recovery FSM.
// Optional error deadband enabled by defining CTRL_DEADBAND_EN.
module line_follow_ctrl
    import line_follow_pkg::*;
#(
    parameter int IMG_W        = 640,
    parameter int PWM_PERIOD   = 1000,
    parameter int BASE_DUTY    = 600,
    parameter int KP_SHIFT     = 2,
    parameter int SEARCH_DUTY  = 300,
    parameter int LOST_TIMEOUT = 8,
    parameter int DEADBAND     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd,
    input  logic [10:0]             centroid_x,
    input  logic                    line_valid,
    input  logic                    line_lost,
    output logic                    pwm_left,
    output logic                    pwm_right,
    output logic signed [ERR_W-1:0] steer_err,
    output logic [1:0]              ctrl_state
);

    localparam int DW = duty_w(PWM_PERIOD);
    localparam int LW = $clog2(LOST_TIMEOUT + 1);
    localparam logic [LW-1:0] LOST_MAX = LW'(LOST_TIMEOUT);
    localparam logic signed [ERR_W:0] PERIOD_S = (ERR_W+1)'(PWM_PERIOD);
    localparam logic signed [ERR_W:0] BASE_S   = (ERR_W+1)'(BASE_DUTY);

    ctrl_state_t state, state_nxt;
    logic [LW-1:0] lost_cnt, lost_nxt, lost_inc;
    logic [10:0] cx;
    logic signed [ERR_W-1:0] err_new, corr;
    logic signed [ERR_W:0] duty_l_s, duty_r_s;
    logic [DW-1:0] load_l, load_r;
    logic load;

    // Error datapath
    always_comb begin
        cx       = (centroid_x > 11'(IMG_W - 1)) ? 11'(IMG_W - 1) : centroid_x;
        err_new  = $signed({1'b0, cx}) - $signed(ERR_W'(IMG_W / 2));
        corr     = err_new >>> KP_SHIFT;
`ifdef CTRL_DEADBAND_EN
        if ((err_new <= $signed(ERR_W'(DEADBAND))) && (err_new >= -$signed(ERR_W'(DEADBAND))))
            corr = '0;
`endif
        duty_l_s = clamp_duty(BASE_S + {corr[ERR_W-1], corr}, PERIOD_S);
        duty_r_s = clamp_duty(BASE_S - {corr[ERR_W-1], corr}, PERIOD_S);
    end

    assign lost_inc = (lost_cnt == LOST_MAX) ? lost_cnt : lost_cnt + LW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lost_cnt  <= '0;
            steer_err <= '0;
        end else begin
            state    <= state_nxt;
            lost_cnt <= lost_nxt;
            if (upd && line_valid)
                steer_err <= err_new;
        end
    end

    always_comb begin
        state_nxt = state;
        lost_nxt  = lost_cnt;
        if (upd) begin
            if (line_valid) begin
                state_nxt = TRACK;
                lost_nxt  = '0;
            end else if (line_lost) begin
                lost_nxt = lost_inc;
                // An idle controller never started tracking, so there is nothing to recover.
                if (state != IDLE)
                    state_nxt = (lost_inc == LOST_MAX) ? STOP : SEARCH;
            end
        end
    end

    always_comb begin
        load   = upd && (line_valid || line_lost);
        load_l = '0;
        load_r = '0;
        case (state_nxt)
            TRACK: begin
                load_l = DW'(duty_l_s);
                load_r = DW'(duty_r_s);
            end
            SEARCH: begin
                if (steer_err < 0)
                    load_r = DW'(SEARCH_DUTY);
                else
                    load_l = DW'(SEARCH_DUTY);
            end
            default: ;
        endcase
    end

    assign ctrl_state = state;

    pwm_gen #(
        .PWM_PERIOD(PWM_PERIOD),
        .DW        (DW)
    ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shadow_l (load_l),
        .shadow_r (load_r),
        .pwm_left (pwm_left),
        .pwm_right(pwm_right)
    );

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Self-checking bench for line_follow_ctrl: cycle model of the default instance
// plus duty-count checks on two alternate parameterisations.
module tb_line_follow_ctrl;

    localparam int P = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic upd = 1'b0;
    logic [10:0] centroid_x = '0;
    logic line_valid = 1'b0;
    logic line_lost = 1'b0;

    logic pl0, pr0, pl1, pr1, pl2, pr2;
    logic signed [11:0] se0, se1, se2;
    logic [1:0] st0, st1, st2;

    int checks = 0;
    int errors = 0;
    int cl0, cr0, cl1, cr1, cl2, cr2;

    always #5 clk = ~clk;

    line_follow_ctrl u_dut (
        .clk(clk), .rst(rst), .upd(upd), .centroid_x(centroid_x),
        .line_valid(line_valid), .line_lost(line_lost),
        .pwm_left(pl0), .pwm_right(pr0), .steer_err(se0), .ctrl_state(st0));

    line_follow_ctrl #(.BASE_DUTY(900), .KP_SHIFT(0)) u_dut_clamp (
        .clk(clk), .rst(rst), .upd(upd), .centroid_x(centroid_x),
        .line_valid(line_valid), .line_lost(line_lost),
        .pwm_left(pl1), .pwm_right(pr1), .steer_err(se1), .ctrl_state(st1));

    line_follow_ctrl #(.KP_SHIFT(0)) u_dut_kp0 (
        .clk(clk), .rst(rst), .upd(upd), .centroid_x(centroid_x),
        .line_valid(line_valid), .line_lost(line_lost),
        .pwm_left(pl2), .pwm_right(pr2), .steer_err(se2), .ctrl_state(st2));

    // Reference model of the default-parameter controller.
    int m_state, m_err, m_lost, m_sh_l, m_sh_r, m_act_l, m_act_r, m_pcnt;
    bit m_pwm_l, m_pwm_r;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_err = 0; m_lost = 0;
            m_sh_l = 0; m_sh_r = 0; m_act_l = 0; m_act_r = 0;
            m_pcnt = 0; m_pwm_l = 0; m_pwm_r = 0;
        end else begin
            int cx, e, c;
            m_pwm_l = (m_pcnt < m_act_l);
            m_pwm_r = (m_pcnt < m_act_r);
            if (m_pcnt == P - 1) begin
                m_act_l = m_sh_l; m_act_r = m_sh_r; m_pcnt = 0;
            end else begin
                m_pcnt++;
            end
            if (upd && line_valid) begin
                cx = int'(centroid_x);
                if (cx > 639) cx = 639;
                e = cx - 320;
                c = e >>> 2;
`ifdef CTRL_DEADBAND_EN
                if (e <= 8 && e >= -8) c = 0;
`endif
                m_err = e; m_state = 1; m_lost = 0;
                m_sh_l = 600 + c; m_sh_r = 600 - c;
                if (m_sh_l < 0) m_sh_l = 0;
                if (m_sh_l > P) m_sh_l = P;
                if (m_sh_r < 0) m_sh_r = 0;
                if (m_sh_r > P) m_sh_r = P;
            end else if (upd && line_lost) begin
                if (m_lost < 8) m_lost++;
                if (m_state != 0) m_state = (m_lost == 8) ? 3 : 2;
                m_sh_l = 0; m_sh_r = 0;
                if (m_state == 2) begin
                    if (m_err < 0) m_sh_r = 300; else m_sh_l = 300;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_state", int'(st0), m_state);
        chk("model_err", int'(se0), m_err);
        chk("model_pwm_l", int'(pl0), int'(m_pwm_l));
        chk("model_pwm_r", int'(pr0), int'(m_pwm_r));
    end

    task automatic send(input int cx, input bit v, input bit l);
        @(posedge clk); #2;
        centroid_x = 11'(cx); line_valid = v; line_lost = l; upd = 1'b1;
        @(posedge clk); #2;
        upd = 1'b0; line_valid = 1'b0; line_lost = 1'b0;
    endtask

    task automatic measure();
        repeat (P + 2) @(posedge clk);
        cl0 = 0; cr0 = 0; cl1 = 0; cr1 = 0; cl2 = 0; cr2 = 0;
        repeat (P) begin
            @(negedge clk);
            cl0 += int'(pl0); cr0 += int'(pr0);
            cl1 += int'(pl1); cr1 += int'(pr1);
            cl2 += int'(pl2); cr2 += int'(pr2);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        // Reset state and a warm-up strobe
        chk("reset_state", int'(st0), 0);
        chk("reset_err", int'(se0), 0);
        chk("reset_pwm_l", int'(pl0), 0);
        chk("reset_pwm_r", int'(pr0), 0);
        send(0, 1'b0, 1'b0);
        chk("warmup_state", int'(st0), 0);
        send(0, 1'b0, 1'b1);
        chk("idle_lost_state", int'(st0), 0);

        // Right of centre
        send(400, 1'b1, 1'b0);
        chk("right_err", int'(se0), 80);
        chk("right_state", int'(st0), 1);
        measure();
        chk("right_duty_l", cl0, 620);
        chk("right_duty_r", cr0, 580);

        // Lost recovery
        send(0, 1'b0, 1'b1);
        chk("search_state", int'(st0), 2);
        measure();
        chk("search_duty_l", cl0, 300);
        chk("search_duty_r", cr0, 0);
        for (int i = 0; i < 6; i++) send(0, 1'b0, 1'b1);
        chk("lost7_state", int'(st0), 2);
        send(0, 1'b0, 1'b1);
        chk("stop_state", int'(st0), 3);
        measure();
        chk("stop_duty_l", cl0, 0);
        chk("stop_duty_r", cr0, 0);
        send(320, 1'b1, 1'b0);
        chk("resume_state", int'(st0), 1);
        measure();
        chk("centre_duty_l", cl0, 600);
        chk("centre_duty_r", cr0, 600);

        // Left edge, then search toward the left
        send(0, 1'b1, 1'b0);
        chk("left_err", int'(se0), -320);
        measure();
        chk("left_duty_l", cl0, 520);
        chk("left_duty_r", cr0, 680);
        send(0, 1'b0, 1'b1);
        measure();
        chk("search_left_l", cl0, 0);
        chk("search_left_r", cr0, 300);

        // Right edge with saturating duty on the high-gain instance
        send(639, 1'b1, 1'b0);
        chk("edge_err", int'(se0), 319);
        measure();
        chk("edge_duty_l", cl0, 679);
        chk("edge_duty_r", cr0, 521);
        chk("clamp_duty_l", cl1, 1000);
        chk("clamp_duty_r", cr1, 581);

        // Out-of-range centroid clamps to the last column
        send(2000, 1'b1, 1'b0);
        chk("oob_err", int'(se0), 319);

        // Back-to-back updates: only the latest applies
        send(400, 1'b1, 1'b0);
        send(240, 1'b1, 1'b0);
        measure();
        chk("latest_duty_l", cl0, 580);
        chk("latest_duty_r", cr0, 620);

        // Small error, deadband-dependent
        send(325, 1'b1, 1'b0);
        chk("small_err", int'(se0), 5);
        measure();
`ifdef CTRL_DEADBAND_EN
        chk("db_duty_l", cl0, 600);
        chk("db_duty_r", cr0, 600);
        chk("db_kp0_l", cl2, 600);
        chk("db_kp0_r", cr2, 600);
`else
        chk("nodb_duty_l", cl0, 601);
        chk("nodb_duty_r", cr0, 599);
        chk("nodb_kp0_l", cl2, 605);
        chk("nodb_kp0_r", cr2, 595);
`endif

        // Asynchronous reset while the left output is high
        n = 0;
        while (pl0 !== 1'b1 && n < 2 * P) begin
            @(negedge clk);
            n++;
        end
        chk("pwm_high_seen", int'(pl0), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_pwm_l", int'(pl0), 0);
        chk("async_pwm_r", int'(pr0), 0);
        chk("async_state", int'(st0), 0);
        chk("async_err", int'(se0), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("post_reset_state", int'(st0), 0);
        chk("post_reset_pwm_l", int'(pl0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
